// File: rtl/fetch_stage.sv
// fetch_stage: front end of the pipeline. Generates the program counter,
// issues instruction-memory reads (one outstanding at most), buffers a single
// returned instruction and hands {program_count, instruction_data} to decode
// using a done/stall handshake. A redirect from decode flushes the buffer,
// optionally reloads the PC and marks any in-flight response as wrong-path.
//
// Ports
//   clk, rst                    clock; synchronous active-low reset
//   next_stall                  decode not ready
//   done_next                   output valid (transfer = done_next && !next_stall)
//   program_count_out/_valid    address of the buffered instruction
//   instruction_data_out/_valid instruction word; valid is 0 on a memory fault
//   control_flow_affected       redirect request from decode (combinational)
//   jump_target/_valid          redirect address and its qualifier
//   imem_addr/imem_req/imem_ack request channel (committed on req && ack)
//   imem_rdata/_valid/imem_fault response channel (1-cycle strobe)
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    localparam int ADDR_WIDTH        = 32,
    localparam int INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         next_stall,
    output logic                         done_next,
    output logic [ADDR_WIDTH-1:0]        program_count_out,
    output logic                         program_count_valid_out,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_data_out,
    output logic                         instruction_data_valid_out,
    input  logic                         control_flow_affected,
    input  logic [ADDR_WIDTH-1:0]        jump_target,
    input  logic                         jump_target_valid,
    output logic [ADDR_WIDTH-1:0]        imem_addr,
    output logic                         imem_req,
    input  logic                         imem_ack,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
    input  logic                         imem_rdata_valid,
    input  logic                         imem_fault
);

    logic [ADDR_WIDTH-1:0]        pc;
    logic [ADDR_WIDTH-1:0]        req_addr;
    logic                         outstanding;
    logic                         drop;
    logic                         has_output;
    logic [ADDR_WIDTH-1:0]        buf_addr;
    logic                         buf_addr_valid;
    logic [INSTRUCTION_WIDTH-1:0] buf_data;
    logic                         buf_data_valid;

    logic transfer;
    logic accept;
    logic response;
    logic load;

    always_comb begin
        done_next = rst && has_output && !control_flow_affected;
        transfer  = done_next && !next_stall;
        // A new request may go out only when the buffer will have room for
        // its response: either it is empty or it empties this cycle.
        imem_req  = rst && !outstanding && (!has_output || transfer)
                    && !control_flow_affected;
        imem_addr = pc;
        accept    = imem_req && imem_ack;
        // Responses with nothing outstanding (e.g. left over from before a
        // reset) are strays and are ignored.
        response  = imem_rdata_valid && outstanding;
        // A response arriving during a redirect is wrong-path as well.
        load      = response && !drop && !control_flow_affected;
    end

    assign program_count_out          = buf_addr;
    assign program_count_valid_out    = buf_addr_valid;
    assign instruction_data_out       = buf_data;
    assign instruction_data_valid_out = buf_data_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc             <= RESET_VECTOR;
            req_addr       <= '0;
            outstanding    <= 1'b0;
            drop           <= 1'b0;
            has_output     <= 1'b0;
            buf_addr       <= '0;
            buf_addr_valid <= 1'b0;
            buf_data       <= '0;
            buf_data_valid <= 1'b0;
        end else begin
            // A redirect never coincides with an accept because imem_req is
            // masked during it; the target is taken verbatim.
            if (control_flow_affected && jump_target_valid) begin
                pc <= jump_target;
            end else if (accept) begin
                pc <= pc + 32'd4;
            end

            if (accept) begin
                outstanding <= 1'b1;
                req_addr    <= pc;
            end else if (response) begin
                outstanding <= 1'b0;
            end

            // drop marks the single in-flight response as wrong-path. A
            // response in the redirect cycle itself is discarded via load,
            // so drop is only armed while the response is still pending.
            if (response) begin
                drop <= 1'b0;
            end else if (control_flow_affected && outstanding) begin
                drop <= 1'b1;
            end

            if (control_flow_affected) begin
                has_output <= 1'b0;
            end else if (load) begin
                has_output <= 1'b1;
            end else if (transfer) begin
                has_output <= 1'b0;
            end

            if (load) begin
                buf_addr       <= req_addr;
                buf_addr_valid <= 1'b1;
                buf_data       <= imem_rdata;
                buf_data_valid <= !imem_fault;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized traffic.
// The reference model treats the stage as an instruction stream: decode must
// see pc, pc+4, pc+8 ... starting at the reset vector or at the latest
// redirect target, each with the memory contents of that address.
module tb_fetch_stage;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        next_stall;
    logic        done_next;
    logic [31:0] program_count_out;
    logic        program_count_valid_out;
    logic [31:0] instruction_data_out;
    logic        instruction_data_valid_out;
    logic        control_flow_affected;
    logic [31:0] jump_target;
    logic        jump_target_valid;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_rdata_valid;
    logic        imem_fault;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_VECTOR(RV)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .next_stall                 (next_stall),
        .done_next                  (done_next),
        .program_count_out          (program_count_out),
        .program_count_valid_out    (program_count_valid_out),
        .instruction_data_out       (instruction_data_out),
        .instruction_data_valid_out (instruction_data_valid_out),
        .control_flow_affected      (control_flow_affected),
        .jump_target                (jump_target),
        .jump_target_valid          (jump_target_valid),
        .imem_addr                  (imem_addr),
        .imem_req                   (imem_req),
        .imem_ack                   (imem_ack),
        .imem_rdata                 (imem_rdata),
        .imem_rdata_valid           (imem_rdata_valid),
        .imem_fault                 (imem_fault)
    );

    int checks = 0;
    int passes = 0;
    int xfer_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %b, expected %b", name, act, req);
    endtask

    // ---------------- memory contents and reference model ----------------
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic mem_fault(input logic [31:0] a);
        return ((a >> 2) % 11) == 3;
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        dv;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_pc;

    task automatic topup();
        exp_t e;
        while (exp_q.size() < 4) begin
            e.pc   = model_pc;
            e.data = mem_data(model_pc);
            e.dv   = !mem_fault(model_pc);
            exp_q.push_back(e);
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] a);
        exp_q.delete();
        model_pc = a;
        topup();
    endtask

    // ---------------- instruction memory ----------------
    int          mem_min_wait = 0;
    int          mem_max_wait = 0;
    int          ack_pct = 100;
    logic        stray_en = 1'b0;
    logic        force_stray = 1'b0;
    logic        mem_busy;
    int          mem_wait;
    logic [31:0] mem_addr;
    logic [31:0] req_log[$];

    initial begin : memory
        logic        acc;
        logic        dlv;
        logic [31:0] a;
        mem_busy = 1'b0;
        mem_wait = 0;
        mem_addr = '0;
        imem_ack = 1'b0;
        imem_rdata_valid = 1'b0;
        imem_rdata = '0;
        imem_fault = 1'b0;
        forever begin
            @(negedge clk);
            acc = imem_req && imem_ack;
            dlv = imem_rdata_valid && mem_busy;
            a   = imem_addr;
            @(posedge clk);
            #2;
            if (acc) begin
                mem_busy = 1'b1;
                mem_addr = a;
                mem_wait = int'($urandom_range(mem_min_wait, mem_max_wait));
                req_log.push_back(a);
            end else if (dlv) begin
                mem_busy = 1'b0;
            end else if (mem_busy && mem_wait > 0) begin
                mem_wait--;
            end
            if (mem_busy && mem_wait == 0) begin
                imem_rdata_valid = 1'b1;
                imem_rdata       = mem_data(mem_addr);
                imem_fault       = mem_fault(mem_addr);
            end else if (!mem_busy && (force_stray || (stray_en && $urandom_range(0, 15) == 0))) begin
                imem_rdata_valid = 1'b1;
                imem_rdata       = $urandom;
                imem_fault       = 1'($urandom_range(0, 1));
                force_stray      = 1'b0;
            end else begin
                imem_rdata_valid = 1'b0;
                imem_rdata       = $urandom;
                imem_fault       = 1'($urandom_range(0, 1));
            end
            imem_ack = !mem_busy && (int'($urandom_range(0, 99)) < ack_pct);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic        prev_hold;
        logic [31:0] prev_pc;
        logic [31:0] prev_data;
        logic        prev_dv;
        exp_t        e;
        prev_hold = 1'b0;
        prev_pc   = '0;
        prev_data = '0;
        prev_dv   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst || control_flow_affected) begin
                check_bit("masked_done", done_next, 1'b0);
                check_bit("masked_req", imem_req, 1'b0);
            end
            if (done_next && next_stall) begin
                check_bit("stall_no_req", imem_req, 1'b0);
                if (prev_hold) begin
                    check("stall_pc_stable", program_count_out, prev_pc);
                    check("stall_data_stable", instruction_data_out, prev_data);
                    check_bit("stall_dv_stable", instruction_data_valid_out, prev_dv);
                end
            end
            if (done_next && !next_stall) begin
                e = exp_q.pop_front();
                check("xfer_pc", program_count_out, e.pc);
                check("xfer_data", instruction_data_out, e.data);
                check_bit("xfer_data_valid", instruction_data_valid_out, e.dv);
                check_bit("xfer_pc_valid", program_count_valid_out, 1'b1);
                xfer_count++;
                topup();
            end
            prev_hold = done_next && next_stall;
            prev_pc   = program_count_out;
            prev_data = instruction_data_out;
            prev_dv   = instruction_data_valid_out;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_next) begin
                ok = 1'b1;
                break;
            end
        end
        check_bit(name, ok, 1'b1);
    endtask

    task automatic wait_accept(input string name, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (imem_req && imem_ack) begin
                ok = 1'b1;
                break;
            end
        end
        check_bit(name, ok, 1'b1);
    endtask

    initial begin : stimulus
        logic        ok;
        logic [31:0] held_pc;
        logic [31:0] held_data;
        logic [31:0] target;
        int          rst_left;
        int          redir_left;
        int          redir_nval;
        int          cyc;
        int          xfer_base;
        int          r;

        rst = 1'b0;
        next_stall = 1'b0;
        control_flow_affected = 1'b0;
        jump_target_valid = 1'b0;
        jump_target = '0;
        restart(RV);

        // Reset, first request, latency and sequential fetch.
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        check_bit("first_req_valid", imem_req, 1'b1);
        check("first_req_addr", imem_addr, RV);
        @(negedge clk);
        check_bit("latency_not_early", done_next, 1'b0);
        @(negedge clk);
        check_bit("latency_done", done_next, 1'b1);
        repeat (6) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("seq_req%0d", k), (k < req_log.size()) ? req_log[k] : 32'hFFFF_FFFF,
                  RV + 32'(4 * k));
        end

        // Backpressure.
        tick();
        next_stall = 1'b1;
        wait_done("bp_wait_done", 20, ok);
        if (ok) begin
            held_pc   = program_count_out;
            held_data = instruction_data_out;
            repeat (5) begin
                @(negedge clk);
                check_bit("bp_done_held", done_next, 1'b1);
                check_bit("bp_no_req", imem_req, 1'b0);
            end
            check("bp_pc_stable", program_count_out, held_pc);
            check("bp_data_stable", instruction_data_out, held_data);
            tick();
            next_stall = 1'b0;
            @(negedge clk);
            check_bit("bp_release_xfer", done_next, 1'b1);
            check_bit("bp_release_req", imem_req, 1'b1);
            check("bp_release_addr", imem_addr, held_pc + 32'd4);
        end

        // Redirect while a response is in flight.
        mem_min_wait = 2;
        mem_max_wait = 2;
        wait_accept("rd_wait_accept", 20, ok);
        tick();
        control_flow_affected = 1'b1;
        jump_target_valid = 1'b1;
        jump_target = 32'h0000_2000;
        restart(32'h0000_2000);
        tick();
        control_flow_affected = 1'b0;
        jump_target_valid = 1'b0;
        wait_done("rd_wait_done", 30, ok);
        check("rd_target_pc", program_count_out, 32'h0000_2000);

        // Redirect held while the target is not yet valid.
        mem_min_wait = 0;
        mem_max_wait = 0;
        tick();
        control_flow_affected = 1'b1;
        jump_target_valid = 1'b0;
        jump_target = 32'hDEAD_BEE0;
        restart(32'h0000_0040);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_bit("tnv_no_req", imem_req, 1'b0);
            tick();
        end
        jump_target_valid = 1'b1;
        jump_target = 32'h0000_0040;
        @(negedge clk);
        check_bit("tnv_no_req_target", imem_req, 1'b0);
        tick();
        control_flow_affected = 1'b0;
        jump_target_valid = 1'b0;
        @(negedge clk);
        check_bit("tnv_first_req", imem_req, 1'b1);
        check("tnv_first_addr", imem_addr, 32'h0000_0040);
        @(negedge clk);
        @(negedge clk);
        check_bit("tnv_bubble_done", done_next, 1'b1);
        check("tnv_bubble_pc", program_count_out, 32'h0000_0040);

        // Faulting fetch, then address wrap.
        tick();
        control_flow_affected = 1'b1;
        jump_target_valid = 1'b1;
        jump_target = 32'h0000_000C;
        restart(32'h0000_000C);
        tick();
        control_flow_affected = 1'b0;
        jump_target_valid = 1'b0;
        wait_done("fault_wait_done", 20, ok);
        check("fault_pc", program_count_out, 32'h0000_000C);
        check_bit("fault_data_valid", instruction_data_valid_out, 1'b0);
        check_bit("fault_pc_valid", program_count_valid_out, 1'b1);
        tick();
        control_flow_affected = 1'b1;
        jump_target_valid = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        restart(32'hFFFF_FFFC);
        tick();
        control_flow_affected = 1'b0;
        jump_target_valid = 1'b0;
        @(negedge clk);
        check("wrap_req_top", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        @(negedge clk);
        check_bit("wrap_req_valid", imem_req, 1'b1);
        check("wrap_req_zero", imem_addr, 32'h0000_0000);

        // Reset while a request is outstanding.
        mem_min_wait = 2;
        mem_max_wait = 2;
        wait_accept("rst_wait_accept", 20, ok);
        tick();
        rst = 1'b0;
        restart(RV);
        tick();
        tick();
        tick();
        rst = 1'b1;
        force_stray = 1'b1;
        @(negedge clk);
        check_bit("rst_first_req", imem_req, 1'b1);
        check("rst_first_addr", imem_addr, RV);
        wait_done("rst_wait_done", 20, ok);
        check("rst_first_pc", program_count_out, RV);
        check("rst_first_data", instruction_data_out, mem_data(RV));

        // Randomized traffic.
        mem_min_wait = 0;
        mem_max_wait = 3;
        ack_pct = 70;
        stray_en = 1'b1;
        xfer_base = xfer_count;
        rst_left = 0;
        redir_left = 0;
        redir_nval = 0;
        cyc = 0;
        while (cyc < 3000 || redir_left > 0 || rst_left > 0) begin
            tick();
            cyc++;
            next_stall = (int'($urandom_range(0, 99)) < 30);
            if (rst_left == 0 && redir_left == 0) begin
                rst = 1'b1;
                control_flow_affected = 1'b0;
                jump_target_valid = 1'b0;
                jump_target = $urandom;
                r = int'($urandom_range(0, 299));
                if (r == 0 && cyc < 3000) begin
                    rst_left = int'($urandom_range(1, 3));
                    restart(RV);
                end else if (r < 10 && cyc < 3000) begin
                    case ($urandom_range(0, 3))
                        0:       target = 32'hFFFF_FFF8;
                        1:       target = $urandom;
                        default: target = $urandom & 32'hFFFF_FFFC;
                    endcase
                    redir_nval = int'($urandom_range(1, 2));
                    redir_left = int'($urandom_range(0, 2)) + redir_nval;
                    restart(target);
                end
            end
            if (rst_left > 0) begin
                rst = 1'b0;
                control_flow_affected = 1'b0;
                jump_target_valid = 1'b0;
                rst_left--;
            end else if (redir_left > 0) begin
                rst = 1'b1;
                control_flow_affected = 1'b1;
                jump_target_valid = (redir_left <= redir_nval);
                jump_target = jump_target_valid ? target : $urandom;
                redir_left--;
            end
        end
        tick();
        rst = 1'b1;
        control_flow_affected = 1'b0;
        jump_target_valid = 1'b0;
        next_stall = 1'b0;
        repeat (10) @(negedge clk);
        check_bit("random_progress", (xfer_count - xfer_base) >= 200, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
